// File: rtl/jseq_pkg.sv
// +----------------------------------------------------------------------------+
// | jseq_pkg : shared encodings for the junction sequencer                     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package jseq_pkg;

  typedef enum logic [2:0] {
    CMD_FOLLOW = 3'd0,
    CMD_STOP   = 3'd1,
    CMD_FWD    = 3'd2,
    CMD_SPIN_L = 3'd3,
    CMD_SPIN_R = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    DIR_STRAIGHT = 2'd0,
    DIR_LEFT     = 2'd1,
    DIR_RIGHT    = 2'd2,
    DIR_BACK     = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TONE = 3'd1,
    ST_CLEAR     = 3'd2,
    ST_TURN      = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  localparam int c_PRESCALE_W = 17;
  localparam int c_PHASE_W    = 16;

endpackage

`default_nettype wire

// File: rtl/ms_tick_gen.sv
// +----------------------------------------------------------------------------+
// | ms_tick_gen : millisecond prescaler with clear/freeze, one-cycle tick      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module ms_tick_gen
  import jseq_pkg::*;
#(
  parameter int CYC_PER_MS = 50_000
) (
  input  logic clk,
  input  logic rstN,
  input  logic clear,
  input  logic freeze,
  output logic tick
);

  localparam logic [c_PRESCALE_W-1:0] c_LAST_CNT = c_PRESCALE_W'(CYC_PER_MS - 1);

  logic [c_PRESCALE_W-1:0] r_cnt;

  // Tick is not gated by clear: clear is derived from the tick-driven transition.
  assign tick = (r_cnt == c_LAST_CNT) && !freeze;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (!freeze) begin
      if (r_cnt == c_LAST_CNT) r_cnt <= '0;
      else                     r_cnt <= r_cnt + c_PRESCALE_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/junction_sequencer.sv
// +----------------------------------------------------------------------------+
// | junction_sequencer : stop, await tone, clear junction, turn, hand back     |
// | Optional: JSEQ_TONE_TIMEOUT_EN enables the tone wait timeout.              |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module junction_sequencer
  import jseq_pkg::*;
#(
  parameter int CYC_PER_MS      = 50_000,
  parameter int CLEAR_MS        = 300,
  parameter int TURN_MS         = 600,
  parameter int TONE_STABLE     = 3,
  parameter int TONE_TIMEOUT_MS = 2000
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       junctionDet,
  input  logic       colDetect,
  input  logic       tdEn,
  input  logic [1:0] tdDir,
  output logic [2:0] cmd,
  output logic       busy,
  output logic       done,
  output logic [1:0] dirOut,
  output logic       toneTimeout
);

  localparam int c_STAB_W = (TONE_STABLE < 1) ? 1 : $clog2(TONE_STABLE + 1);

  state_e                r_state, w_nextState;
  cmd_e                  r_cmd, w_cmdNext;
  dir_e                  r_dirOut, w_dirNext;
  logic                  r_busy, r_done;
  logic                  r_jdPrev, r_jdArmed;
  logic [1:0]            r_prevDir, w_prevDirNext;
  logic [c_STAB_W-1:0]   r_stab, w_stabNext;
  logic [c_PHASE_W-1:0]  r_phase, w_phaseLast;
  logic                  w_tick, w_timed, w_freeze, w_clear, w_jdEdge, w_phaseDone;
`ifdef JSEQ_TONE_TIMEOUT_EN
  logic                  w_timeout;
  logic                  r_toneTimeout;
`endif

  // Armed flag keeps a level still high after reset from reading as an edge.
  assign w_jdEdge    = r_jdArmed && !r_jdPrev && junctionDet;
  assign w_timed     = (r_state == ST_WAIT_TONE) || (r_state == ST_CLEAR) || (r_state == ST_TURN);
  assign w_freeze    = w_timed && colDetect;
  assign w_clear     = (w_nextState != r_state);
  assign w_phaseDone = w_tick && (r_phase == w_phaseLast);

  ms_tick_gen #(.CYC_PER_MS(CYC_PER_MS)) u_tick (
    .clk    (clk),
    .rstN   (rstN),
    .clear  (w_clear),
    .freeze (w_freeze),
    .tick   (w_tick)
  );

  always_comb begin
    w_phaseLast = '1;
    case (r_state)
      ST_WAIT_TONE: w_phaseLast = c_PHASE_W'(TONE_TIMEOUT_MS - 1);
      ST_CLEAR:     w_phaseLast = c_PHASE_W'(CLEAR_MS - 1);
      ST_TURN: begin
        if (r_dirOut == DIR_BACK) w_phaseLast = c_PHASE_W'(2 * TURN_MS - 1);
        else                      w_phaseLast = c_PHASE_W'(TURN_MS - 1);
      end
      default:      w_phaseLast = '1;
    endcase
  end

  always_comb begin
    w_nextState   = r_state;
    w_dirNext     = r_dirOut;
    w_stabNext    = r_stab;
    w_prevDirNext = r_prevDir;
`ifdef JSEQ_TONE_TIMEOUT_EN
    w_timeout     = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_jdEdge) w_nextState = ST_WAIT_TONE;
      end
      ST_WAIT_TONE: begin
        if (w_tick) begin
          w_prevDirNext = tdDir;
          if (!tdEn)                  w_stabNext = '0;
          else if (tdDir == r_prevDir) w_stabNext = r_stab + c_STAB_W'(1);
          else                        w_stabNext = c_STAB_W'(1);
          if (tdEn && (w_stabNext == c_STAB_W'(TONE_STABLE))) begin
            w_dirNext = dir_e'(tdDir);
            if (dir_e'(tdDir) == DIR_BACK) w_nextState = ST_TURN;
            else                           w_nextState = ST_CLEAR;
          end
`ifdef JSEQ_TONE_TIMEOUT_EN
          else if (w_phaseDone) begin
            w_timeout   = 1'b1;
            w_dirNext   = DIR_STRAIGHT;
            w_nextState = ST_CLEAR;
          end
`endif
        end
      end
      ST_CLEAR: begin
        if (w_phaseDone) begin
          if (r_dirOut == DIR_STRAIGHT) w_nextState = ST_DONE;
          else                          w_nextState = ST_TURN;
        end
      end
      ST_TURN: begin
        if (w_phaseDone) w_nextState = ST_DONE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they align with the registered state.
  always_comb begin
    w_cmdNext = CMD_STOP;
    case (w_nextState)
      ST_IDLE:  w_cmdNext = CMD_FOLLOW;
      ST_CLEAR: w_cmdNext = CMD_FWD;
      ST_TURN: begin
        if (w_dirNext == DIR_RIGHT) w_cmdNext = CMD_SPIN_R;
        else                        w_cmdNext = CMD_SPIN_L;
      end
      default:  w_cmdNext = CMD_STOP;
    endcase
    if (w_freeze) w_cmdNext = CMD_STOP;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_jdPrev  <= 1'b0;
      r_jdArmed <= 1'b0;
    end else begin
      r_jdPrev  <= junctionDet;
      r_jdArmed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state   <= ST_IDLE;
      r_cmd     <= CMD_FOLLOW;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dirOut  <= DIR_STRAIGHT;
      r_phase   <= '0;
      r_stab    <= '0;
      r_prevDir <= 2'b00;
    end else begin
      r_state  <= w_nextState;
      r_cmd    <= w_cmdNext;
      r_busy   <= (w_nextState != ST_IDLE);
      r_done   <= (w_nextState == ST_DONE);
      r_dirOut <= w_dirNext;
      if (w_clear) begin
        r_phase   <= '0;
        r_stab    <= '0;
        r_prevDir <= 2'b00;
      end else begin
        // Saturate so an indefinite tone wait never wraps.
        if (w_tick && (r_phase != '1)) r_phase <= r_phase + c_PHASE_W'(1);
        r_stab    <= w_stabNext;
        r_prevDir <= w_prevDirNext;
      end
    end
  end

`ifdef JSEQ_TONE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_toneTimeout <= 1'b0;
    else       r_toneTimeout <= w_timeout;
  end
  assign toneTimeout = r_toneTimeout;
`else
  assign toneTimeout = 1'b0;
`endif

  assign cmd    = r_cmd;
  assign busy   = r_busy;
  assign done   = r_done;
  assign dirOut = r_dirOut;

endmodule

`default_nettype wire
